ham_8_4_dec: RTL and testbench
==============================

// Module: ham_8_4_dec
// PURPOSE
//  SECDED decoder for the extended Hamming(8,4) code produced by hamming_code_encoder.
//  Accepts 8-bit codewords on a valid/ready stream and emits 4-bit corrected data with error status.
//  Maintains saturating error counters. Two-stage pipeline, one word/cycle throughput.
//  Sits on the read/receive side of the path the (8,4) encoder feeds.
// PARAMETERS
//  CNT_W  16  width of each saturating error counter
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      code_in valid
//  in_ready    out  1      decoder can accept code_in this cycle
//  code_in     in   [8:1]  codeword: c1=p1 c2=p2 c3=d1 c4=p3 c5=d2 c6=d3 c7=d4 c8=overall even parity
//  out_valid   out  1      data_out/status valid
//  out_ready   in   1      downstream accepts output
//  data_out    out  [4:1]  corrected data {d4,d3,d2,d1}
//  err_single  out  1      single-bit error detected and corrected
//  err_double  out  1      uncorrectable double-bit error
//  corr_pos    out  [3:0]  flipped position 1..8; 0 when no correction
//  clr_cnt     in   1      synchronous clear of both counters
//  cnt_single  out  CNT_W  single-error count
//  cnt_double  out  CNT_W  double-error count
// BEHAVIOUR
//  - Reset: s1_valid, s2_valid, out_valid, data_out, err_*, corr_pos, counters all 0; in_ready=0 while rst_n low.
//  - Syndrome: s[0]=c1^c3^c5^c7, s[1]=c2^c3^c6^c7, s[2]=c4^c5^c6^c7; p = XOR of c1..c8.
//  - Classification: s=0,p=0 -> clean; p=1,s!=0 -> single, flip bit s, corr_pos=s;
//    p=1,s=0 -> single in c8, data unchanged, corr_pos=8; p=0,s!=0 -> double, data_out=raw d bits, corr_pos=0.
//  - err_single and err_double are never both 1.
//  - Stage 1 registers code_in, s, p on in_valid&&in_ready. Stage 2 registers corrected data and status.
//  - Latency: word accepted in cycle N appears on out_valid in cycle N+2 (no stall).
//  - Flow control: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
//    in_ready is combinational from out_ready; no combinational path from in_valid to out_*.
//  - Output regs hold stable while out_valid && !out_ready; no word dropped or duplicated under any stall pattern.
//  - Counters increment on out_valid&&out_ready with matching flag; saturate at all-ones (no wrap).
//  - clr_cnt has priority over a same-cycle increment (that event is not counted).
//  - Reset asserted mid-stream: in-flight words discarded, outputs drop to reset values immediately.
// STRUCTURE
//  - Package ham_pkg: CODE_W=8, DATA_W=4, typedef syn_t logic[2:0], enum ham_stat_e {HAM_OK,HAM_SEC,HAM_DED},
//    function ham_8_4_parity() shared with the encoder.
//  - One sub-module: ham_8_4_correct (combinational: code+s+p -> data, status, corr_pos), used in stage 2.
//  - Top holds the two pipeline registers, handshake logic and counters.
// TESTING
//  - All 16 data words encoded, out_ready=1 -> data_out==data, no flags, one output/cycle after 2-cycle fill.
//  - code_in=8'b1110_0001 (data 4'b1100) clean; 8'b1111_0001 -> data_out=1100, err_single, corr_pos=5.
//  - 8'b0110_0001 (c8 flipped) -> data_out=1100, err_single, corr_pos=8; 8'b1110_0010 -> err_double, data_out=1100.
//  - Random out_ready toggling with continuous in_valid over 1000 words -> output sequence equals input order, none lost.
//  - CNT_W=2, five single errors -> cnt_single saturates at 3; clr_cnt with concurrent error -> count 0.
//  - rst_n pulled low with 2 words in flight -> out_valid=0 same cycle, counters 0, in_ready=1 first cycle after release.

Source files
------------

// File: rtl/ham_8_4_dec_pkg.sv
// Shared definitions for the extended Hamming(8,4) SECDED code.
// Codeword bit c(i) sits at index i of a [8:1] vector; c8 is overall even parity.
package ham_pkg;

    localparam int CODE_W = 8;
    localparam int DATA_W = 4;

    typedef logic [CODE_W:1] code_t;
    typedef logic [DATA_W:1] data_t;
    typedef logic [2:0]      syn_t;

    typedef enum logic [1:0] {
        HAM_OK,
        HAM_SEC,
        HAM_DED
    } ham_stat_e;

    // Returns {p3, p2, p1} for data {d4, d3, d2, d1}; the encoder and decoder share it.
    function automatic syn_t ham_8_4_parity(input data_t d);
        return {d[2] ^ d[3] ^ d[4],
                d[1] ^ d[3] ^ d[4],
                d[1] ^ d[2] ^ d[4]};
    endfunction

    function automatic data_t ham_8_4_data(input code_t c);
        return {c[7], c[6], c[5], c[3]};
    endfunction

endpackage

// File: rtl/ham_8_4_dec_if.sv
// Codeword-in / corrected-data-out stream bundle for the Hamming(8,4) decoder.
interface ham_8_4_dec_if;
    import ham_pkg::*;

    logic        in_valid;
    logic        in_ready;
    code_t       code_in;
    logic        out_valid;
    logic        out_ready;
    data_t       data_out;
    logic        err_single;
    logic        err_double;
    logic [3:0]  corr_pos;

    modport master (
        output in_valid, code_in, out_ready,
        input  in_ready, out_valid, data_out, err_single, err_double, corr_pos
    );

    modport slave (
        input  in_valid, code_in, out_ready,
        output in_ready, out_valid, data_out, err_single, err_double, corr_pos
    );

endinterface

// File: rtl/ham_8_4_dec_correct.sv
// Combinational SECDED classification and single-bit correction of one codeword.
module ham_8_4_correct
    import ham_pkg::*;
(
    input  code_t      code_i,
    input  syn_t       syn_i,
    input  logic       par_i,
    output data_t      data_o,
    output ham_stat_e  stat_o,
    output logic [3:0] corr_pos_o
);

    code_t flip;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        flip       = '0;
        stat_o     = HAM_OK;
        corr_pos_o = '0;
        if (par_i) begin
            stat_o = HAM_SEC;
            if (syn_i == '0) begin
                // Error in c8 itself: data bits are already correct.
                corr_pos_o = 4'd8;
            end else begin
                corr_pos_o = {1'b0, syn_i};
                for (int i = 1; i <= 7; i++) begin
                    flip[i] = (syn_i == syn_t'(i));
                end
            end
        end else if (syn_i != '0) begin
            stat_o = HAM_DED;
        end
        data_o = ham_8_4_data(code_i ^ flip);
    end

endmodule

// File: rtl/ham_8_4_dec.sv
// Two-stage Hamming(8,4) SECDED decoder: syndrome stage, correction stage,
// valid/ready flow control and saturating error counters.
module ham_8_4_dec
    import ham_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ham_8_4_dec_if.slave     bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_double
);

    logic       s1_valid_q, s1_valid_d;
    code_t      s1_code_q,  s1_code_d;
    syn_t       s1_syn_q,   s1_syn_d;
    logic       s1_par_q,   s1_par_d;

    logic       s2_valid_q,  s2_valid_d;
    data_t      s2_data_q,   s2_data_d;
    logic       s2_single_q, s2_single_d;
    logic       s2_double_q, s2_double_d;
    logic [3:0] s2_pos_q,    s2_pos_d;

    logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
    logic [CNT_W-1:0] cnt_double_q, cnt_double_d;

    logic       s1_adv, s2_adv, accept, fire;
    data_t      cor_data;
    ham_stat_e  cor_stat;
    logic [3:0] cor_pos;

    // A stage may advance when it is empty or the stage after it is moving.
    assign s2_adv       = !s2_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid_q || s2_adv;
    assign bus.in_ready = rst_n && s1_adv;
    assign accept       = bus.in_valid && bus.in_ready;
    assign fire         = s2_valid_q && bus.out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (s1_adv) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_code_d = bus.code_in;
            s1_syn_d  = {bus.code_in[4], bus.code_in[2], bus.code_in[1]}
                        ^ ham_8_4_parity(ham_8_4_data(bus.code_in));
            s1_par_d  = ^bus.code_in;
        end
    end

    ham_8_4_correct u_correct (
        .code_i     (s1_code_q),
        .syn_i      (s1_syn_q),
        .par_i      (s1_par_q),
        .data_o     (cor_data),
        .stat_o     (cor_stat),
        .corr_pos_o (cor_pos)
    );

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_single_d = s2_single_q;
        s2_double_d = s2_double_q;
        s2_pos_d    = s2_pos_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d   = cor_data;
                s2_single_d = (cor_stat == HAM_SEC);
                s2_double_d = (cor_stat == HAM_DED);
                s2_pos_d    = cor_pos;
            end
        end
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        cnt_single_d = cnt_single_q;
        cnt_double_d = cnt_double_q;
        if (clr_cnt) begin
            cnt_single_d = '0;
            cnt_double_d = '0;
        end else if (fire) begin
            if (s2_single_q && !(&cnt_single_q)) cnt_single_d = cnt_single_q + CNT_W'(1);
            if (s2_double_q && !(&cnt_double_q)) cnt_double_d = cnt_double_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_single_q  <= 1'b0;
            s2_double_q  <= 1'b0;
            s2_pos_q     <= '0;
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_single_q  <= s2_single_d;
            s2_double_q  <= s2_double_d;
            s2_pos_q     <= s2_pos_d;
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.data_out   = s2_data_q;
    assign bus.err_single = s2_single_q;
    assign bus.err_double = s2_double_q;
    assign bus.corr_pos   = s2_pos_q;
    assign cnt_single     = cnt_single_q;
    assign cnt_double     = cnt_double_q;

endmodule

// File: tb/tb_ham_8_4_dec.sv
// Directed bench for ham_8_4_dec: clean words, SEC/DED vectors, counter saturation
// and clear priority, a randomly stalled 1000-word stream, and mid-stream reset.
module tb_ham_8_4_dec;
    import ham_pkg::*;

    localparam int CNT_W = 2;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             clr_cnt = 1'b0;
    logic [CNT_W-1:0] cnt_single;
    logic [CNT_W-1:0] cnt_double;

    int total = 0;
    int bad   = 0;

    ham_8_4_dec_if bus ();

    ham_8_4_dec #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clr_cnt    (clr_cnt),
        .cnt_single (cnt_single),
        .cnt_double (cnt_double)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hand-derived encoder: p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4, c8 = even parity of c1..c7.
    function automatic logic [8:1] enc(input logic [4:1] d);
        logic [7:1] c;
        c = {d[4], d[3], d[2], d[2] ^ d[3] ^ d[4], d[1], d[1] ^ d[3] ^ d[4], d[1] ^ d[2] ^ d[4]};
        return {^c, c};
    endfunction

    function automatic logic [31:0] pk(input logic [4:1] d, input logic s, input logic dd,
                                       input logic [3:0] pos);
        return {22'b0, d, s, dd, pos};
    endfunction

    function automatic logic [31:0] out_word();
        return {22'b0, bus.data_out, bus.err_single, bus.err_double, bus.corr_pos};
    endfunction

    // Called at a negedge with an empty pipeline and out_ready=1; returns one negedge after the
    // output handshake so counter updates are visible.
    task automatic xfer(input logic [8:1] code, input logic [31:0] exp, input string tag);
        bus.in_valid = 1'b1;
        bus.code_in  = code;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_early"}, bus.out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, bus.out_valid, 1);
        check(tag, out_word(), exp);
        @(negedge clk);
    endtask

    initial begin
        logic [8:1] cur_code;
        logic [31:0] cur_exp;
        logic [31:0] q[$];
        logic [4:1] d;
        int pos;
        int sent, got, cyc;

        bus.in_valid  = 1'b0;
        bus.code_in   = '0;
        bus.out_ready = 1'b1;

        #2;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_outputs", out_word(), 0);
        check("rst_cnt", {cnt_single, cnt_double}, 0);

        @(negedge clk);
        rst_n = 1'b1;

        // All 16 data words back to back.
        for (int k = 0; k < 18; k++) begin
            bus.in_valid = (k < 16);
            bus.code_in  = enc(4'(k));
            #1;
            if (k < 16) check("fill_in_ready", bus.in_ready, 1);
            check("fill_out_valid", bus.out_valid, (k >= 2));
            if (k >= 2) check("fill_word", out_word(), pk(4'(k - 2), 1'b0, 1'b0, 4'd0));
            @(negedge clk);
        end
        check("fill_cnt", {cnt_single, cnt_double}, 0);

        xfer(8'b1110_0001, pk(4'b1100, 1'b0, 1'b0, 4'd0), "vec_clean");
        xfer(8'b1111_0001, pk(4'b1100, 1'b1, 1'b0, 4'd5), "vec_sec5");
        xfer(8'b0110_0001, pk(4'b1100, 1'b1, 1'b0, 4'd8), "vec_sec8");
        xfer(8'b1110_0010, pk(4'b1100, 1'b0, 1'b1, 4'd0), "vec_ded");
        check("vec_cnt_single", cnt_single, 2);
        check("vec_cnt_double", cnt_double, 1);

        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("clr_cnt_both", {cnt_single, cnt_double}, 0);

        for (int i = 0; i < 5; i++) begin
            d = 4'(i + 3);
            xfer(enc(d) ^ (8'b1 << i), pk(d, 1'b1, 1'b0, 4'(i + 1)), "sat_word");
        end
        check("sat_cnt_single", cnt_single, 3);
        check("sat_cnt_double", cnt_double, 0);

        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        xfer(enc(4'b1010) ^ 8'b0100_0000, pk(4'b1010, 1'b1, 1'b0, 4'd7), "pre_clr_word");
        check("pre_clr_cnt", cnt_single, 1);

        // Clear lands in the same cycle as a single-error output handshake.
        bus.in_valid = 1'b1;
        bus.code_in  = enc(4'b0110) ^ 8'b0000_0010;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("clr_race_valid", bus.out_valid, 1);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("clr_race_cnt", cnt_single, 0);

        // Continuous in_valid, random out_ready, random single-bit faults.
        sent = 0;
        got  = 0;
        cyc  = 0;
        d    = 4'($urandom_range(0, 15));
        pos  = $urandom_range(0, 8);
        cur_code = enc(d) ^ ((pos != 0) ? (8'b1 << (pos - 1)) : 8'b0);
        cur_exp  = pk(d, (pos != 0), 1'b0, 4'(pos));
        while (got < 1000 && cyc < 6000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = (sent < 1000);
            bus.code_in   = cur_code;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("stream_extra", 1, 0);
                else check("stream_word", out_word(), q.pop_front());
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(cur_exp);
                sent++;
                d   = 4'($urandom_range(0, 15));
                pos = $urandom_range(0, 8);
                cur_code = enc(d) ^ ((pos != 0) ? (8'b1 << (pos - 1)) : 8'b0);
                cur_exp  = pk(d, (pos != 0), 1'b0, 4'(pos));
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream_count", got, 1000);
        check("stream_left", q.size(), 0);

        // Two words in flight behind a stalled output, then reset.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.code_in   = enc(4'b0011);
        @(negedge clk);
        bus.code_in   = enc(4'b1001) ^ 8'b0000_0100;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        check("flight_out_valid", bus.out_valid, 1);
        check("flight_in_ready", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_outputs", out_word(), 0);
        check("midrst_cnt", {cnt_single, cnt_double}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("release_discarded", bus.out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
